memory_wb_stage: RTL and testbench
==================================

Name: memory_wb_stage

Overview:
- Pipelined Y86-64 memory-access stage plus the M-to-W pipeline register. It consumes the M-register outputs of execute and produces the W-register values (icode, Cnd, valE, valM, dstE, dstM, stat) that drive the writeback stage.
- It contains the byte-addressed data memory and resolves memory-address exceptions. It also exposes combinational m_valM/m_stat for forwarding and for the pipeline control logic.

Parameters:
- MEM_BYTES, 1024, data memory size in bytes; must be a multiple of 8.
- ADDR_W, 64, address width, i.e. width of valE/valA used as address.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- M_stat  input  3  incoming status (1=AOK, 2=HLT, 3=ADR, 4=INS).
- M_icode  input  4  instruction code.
- M_Cnd  input  1  condition flag from execute.
- M_valE  input  64  ALU result / effective address.
- M_valA  input  64  store data, or pop/ret address (carries valP for call).
- M_dstE  input  4  destination register for valE; 0xF = none.
- M_dstM  input  4  destination register for valM; 0xF = none.
- W_stall  input  1  hold the W register.
- W_bubble  input  1  load a bubble into the W register.
- m_valM  output  64  combinational memory read data.
- m_stat  output  3  combinational stage status.
- W_stat  output  3  registered status.
- W_icode  output  4  registered icode.
- W_Cnd  output  1  registered Cnd.
- W_valE  output  64  registered valE.
- W_valM  output  64  registered valM.
- W_dstE  output  4  registered dstE.
- W_dstM  output  4  registered dstM.

Behaviour:
- Address select:
  - addr = M_valE for icode 4 (rmmovq), 5 (mrmovq), 8 (call), A (pushq).
  - addr = M_valA for icode 9 (ret), B (popq).
  - No access for any other icode.
- Read enable: icode 5, 9, B. Write enable: icode 4, 8, A. Write data = M_valA.
- dmem_error = access enabled AND (addr > MEM_BYTES-8). The comparison is full ADDR_W width, so addresses near 2^64 do not wrap into range.
- Reads:
  - Combinational, 8 bytes little-endian: m_valM = {mem[addr+7] ... mem[addr]}.
  - m_valM = 0 when there is no read or when dmem_error is set.
- m_stat = 3 (ADR) if dmem_error, else M_stat.
- Writes:
  - 8 bytes little-endian at the rising edge.
  - Performed only if write enabled, not dmem_error, M_stat == AOK, and W_stat is AOK. Once an exception reaches W, younger stores never commit.
  - rst also inhibits the write that cycle.
- A read and write of the same address cannot occur in one instruction. A read in the cycle after a write returns the new data (zero-latency write-through array).
- W register priority per edge: rst > W_bubble > W_stall > load.
  - rst or W_bubble: W_stat=1, W_icode=1 (nop), W_Cnd=0, W_valE=0, W_valM=0, W_dstE=0xF, W_dstM=0xF.
  - W_stall: all W outputs hold.
  - load: W_stat=m_stat, W_valM=m_valM, all other W fields take the corresponding M input.
- Reset values of all W outputs are the bubble values above. Memory contents are not reset.
- Latency: M inputs appear on W outputs one cycle later. m_valM and m_stat have zero latency.
- Reset asserted mid-operation:
  - The W register becomes a bubble next edge.
  - Any store presented in the reset cycle is discarded.

Optional Feature:
- DMEM_ALIGN_CHECK_EN:
  - Defined: an enabled access with addr[2:0] != 0 also sets dmem_error. The result is m_stat=ADR, no write, and m_valM=0.
  - Undefined: unaligned accesses are legal, using byte-granular little-endian read/write at addr..addr+7.

Test Plan:
- Store/load: rmmovq with valE=0x10, valA=0x1122334455667788. Next cycle, mrmovq with valE=0x10 and dstM=3 -> m_valM=0x1122334455667788. One edge later, W_valM equals that value, W_dstM=3, W_stat=1.
- Bounds: mrmovq with valE=MEM_BYTES-7 (1017) -> m_stat=3, m_valM=0, W_stat=3 next edge. Also valE=0xFFFFFFFFFFFFFFFC -> ADR, no wraparound.
- Store suppression: pushq with valE=0x20, valA=0xAA while W_stat=3 held -> mem[0x20..0x27] unchanged, verified by a later read after reset.
- Stall/bubble:
  - Load an OPq (dstE=2, valE=5), then assert W_stall with changing inputs -> W holds dstE=2, valE=5.
  - Assert W_stall and W_bubble together -> W becomes nop, dstE=0xF.
- popq/ret addressing: popq with valA=0x40, valE=0x48, mem[0x40]=0x99 -> m_valM=0x99 and W_valE=0x48. A store of 0x77 with rst high in the same cycle -> location unchanged, W outputs equal bubble values.
- With DMEM_ALIGN_CHECK_EN: mrmovq with valE=0x13 -> m_stat=3. Without the macro -> m_valM = bytes 0x13..0x1A, stat AOK.

Source files
------------

// File: rtl/memory_wb_stage.sv
// Y86-64 memory-access stage with the M-to-W pipeline register and byte-addressed data memory.
// Optional macro DMEM_ALIGN_CHECK_EN: treat enabled accesses with addr[2:0] != 0 as address errors.
module memory_wb_stage #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  M_stat,
  input  logic [3:0]  M_icode,
  input  logic        M_Cnd,
  input  logic [63:0] M_valE,
  input  logic [63:0] M_valA,
  input  logic [3:0]  M_dstE,
  input  logic [3:0]  M_dstM,
  input  logic        W_stall,
  input  logic        W_bubble,
  output logic [63:0] m_valM,
  output logic [2:0]  m_stat,
  output logic [2:0]  W_stat,
  output logic [3:0]  W_icode,
  output logic        W_Cnd,
  output logic [63:0] W_valE,
  output logic [63:0] W_valM,
  output logic [3:0]  W_dstE,
  output logic [3:0]  W_dstM
);

  localparam int IW = $clog2(MEM_BYTES);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_ADR = 3'd3;

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] REG_NONE = 4'hF;

  // Highest legal start address; compared at full width so huge addresses never wrap in.
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(MEM_BYTES - 8);

  logic [7:0]        mem [0:MEM_BYTES-1];
  logic [ADDR_W-1:0] addr;
  logic [IW-1:0]     idx;
  logic              rd_en;
  logic              wr_en;
  logic              dmem_error;
  logic              wr_commit;
  logic [63:0]       rdata;

  always_comb begin
    addr  = '0;
    rd_en = 1'b0;
    wr_en = 1'b0;
    unique case (M_icode)
      I_RMMOVQ, I_CALL, I_PUSHQ: begin
        addr  = M_valE[ADDR_W-1:0];
        wr_en = 1'b1;
      end
      I_MRMOVQ: begin
        addr  = M_valE[ADDR_W-1:0];
        rd_en = 1'b1;
      end
      I_RET, I_POPQ: begin
        addr  = M_valA[ADDR_W-1:0];
        rd_en = 1'b1;
      end
      default: begin
        addr  = '0;
        rd_en = 1'b0;
        wr_en = 1'b0;
      end
    endcase
  end

  assign idx = addr[IW-1:0];

  always_comb begin
    dmem_error = 1'b0;
    if (rd_en || wr_en) begin
`ifdef DMEM_ALIGN_CHECK_EN
      dmem_error = (addr > ADDR_MAX) || (addr[2:0] != 3'b000);
`else
      dmem_error = (addr > ADDR_MAX);
`endif
    end
  end

  always_comb begin
    rdata = '0;
    if (rd_en && !dmem_error) begin
      for (int k = 0; k < 8; k++) begin
        rdata[8*k +: 8] = mem[idx + IW'(k)];
      end
    end
  end

  assign m_valM = rdata;
  assign m_stat = dmem_error ? STAT_ADR : M_stat;

  // Once an exception has reached W, younger stores must not change architectural memory.
  assign wr_commit = !rst && wr_en && !dmem_error &&
                     (M_stat == STAT_AOK) && (W_stat == STAT_AOK);

  always_ff @(posedge clk) begin
    if (wr_commit) begin
      for (int k = 0; k < 8; k++) begin
        mem[idx + IW'(k)] <= M_valA[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || W_bubble) begin
      W_stat  <= STAT_AOK;
      W_icode <= I_NOP;
      W_Cnd   <= 1'b0;
      W_valE  <= '0;
      W_valM  <= '0;
      W_dstE  <= REG_NONE;
      W_dstM  <= REG_NONE;
    end else if (!W_stall) begin
      W_stat  <= m_stat;
      W_icode <= M_icode;
      W_Cnd   <= M_Cnd;
      W_valE  <= M_valE;
      W_valM  <= m_valM;
      W_dstE  <= M_dstE;
      W_dstM  <= M_dstM;
    end
  end

endmodule

// File: tb/tb_memory_wb_stage.sv
// Scoreboard bench for memory_wb_stage: directed vectors push expectations, a negedge monitor checks them.
module tb_memory_wb_stage;

  logic        clk;
  logic        rst;
  logic [2:0]  M_stat;
  logic [3:0]  M_icode;
  logic        M_Cnd;
  logic [63:0] M_valE;
  logic [63:0] M_valA;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;
  logic        W_stall;
  logic        W_bubble;
  logic [63:0] m_valM;
  logic [2:0]  m_stat;
  logic [2:0]  W_stat;
  logic [3:0]  W_icode;
  logic        W_Cnd;
  logic [63:0] W_valE;
  logic [63:0] W_valM;
  logic [3:0]  W_dstE;
  logic [3:0]  W_dstM;

  memory_wb_stage #(.MEM_BYTES(1024), .ADDR_W(64)) dut (
    .clk(clk), .rst(rst),
    .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd),
    .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
    .W_stall(W_stall), .W_bubble(W_bubble),
    .m_valM(m_valM), .m_stat(m_stat),
    .W_stat(W_stat), .W_icode(W_icode), .W_Cnd(W_Cnd),
    .W_valE(W_valE), .W_valM(W_valM), .W_dstE(W_dstE), .W_dstM(W_dstM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    string       name;
    logic [63:0] valM;
    logic [2:0]  stat;
  } m_exp_t;

  typedef struct {
    int          due;
    string       name;
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valM;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } w_exp_t;

  m_exp_t mq[$];
  w_exp_t wq[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  string cur_name;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic drive(input string name, input logic r, input logic [2:0] st, input logic [3:0] ic,
                       input logic cnd, input logic [63:0] ve, input logic [63:0] va,
                       input logic [3:0] de, input logic [3:0] dm, input logic stall, input logic bub);
    @(posedge clk);
    #1;
    cur_name = name;
    rst = r; M_stat = st; M_icode = ic; M_Cnd = cnd; M_valE = ve; M_valA = va;
    M_dstE = de; M_dstM = dm; W_stall = stall; W_bubble = bub;
  endtask

  task automatic exp_m(input logic [63:0] v, input logic [2:0] s);
    m_exp_t e;
    e.due = cyc; e.name = cur_name; e.valM = v; e.stat = s;
    mq.push_back(e);
  endtask

  task automatic exp_w(input logic [2:0] s, input logic [3:0] ic, input logic cnd, input logic [63:0] ve,
                       input logic [63:0] vm, input logic [3:0] de, input logic [3:0] dm);
    w_exp_t e;
    e.due = cyc + 1; e.name = cur_name; e.stat = s; e.icode = ic; e.cnd = cnd;
    e.valE = ve; e.valM = vm; e.dstE = de; e.dstM = dm;
    wq.push_back(e);
  endtask

  task automatic exp_bubble();
    exp_w(3'd1, 4'h1, 1'b0, 64'd0, 64'd0, 4'hF, 4'hF);
  endtask

  always @(negedge clk) begin
    while (mq.size() > 0 && mq[0].due <= cyc) begin
      m_exp_t e;
      e = mq.pop_front();
      checks++;
      if (e.due != cyc || m_valM !== e.valM || m_stat !== e.stat) begin
        errors++;
        $display("FAIL m_%s: got valM=%h stat=%0d, want valM=%h stat=%0d (due %0d at %0d)",
                 e.name, m_valM, m_stat, e.valM, e.stat, e.due, cyc);
      end
    end
    while (wq.size() > 0 && wq[0].due <= cyc) begin
      w_exp_t e;
      e = wq.pop_front();
      checks++;
      if (e.due != cyc || W_stat !== e.stat || W_icode !== e.icode || W_Cnd !== e.cnd ||
          W_valE !== e.valE || W_valM !== e.valM || W_dstE !== e.dstE || W_dstM !== e.dstM) begin
        errors++;
        $display("FAIL w_%s: got stat=%0d icode=%h cnd=%b valE=%h valM=%h dstE=%h dstM=%h, want stat=%0d icode=%h cnd=%b valE=%h valM=%h dstE=%h dstM=%h",
                 e.name, W_stat, W_icode, W_Cnd, W_valE, W_valM, W_dstE, W_dstM,
                 e.stat, e.icode, e.cnd, e.valE, e.valM, e.dstE, e.dstM);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; M_stat = 3'd1; M_icode = 4'h1; M_Cnd = 1'b0; M_valE = '0; M_valA = '0;
    M_dstE = 4'hF; M_dstM = 4'hF; W_stall = 1'b0; W_bubble = 1'b0;

    drive("reset0", 1, 1, 4'h1, 0, 64'd0, 64'd0, 4'hF, 4'hF, 0, 0);
    exp_bubble();
    drive("reset1", 1, 1, 4'h1, 0, 64'd0, 64'd0, 4'hF, 4'hF, 0, 0);
    exp_bubble();

    drive("st10", 0, 1, 4'h4, 0, 64'h10, 64'h1122334455667788, 4'hF, 4'hF, 0, 0);
    exp_m(64'd0, 3'd1);
    exp_w(3'd1, 4'h4, 1'b0, 64'h10, 64'd0, 4'hF, 4'hF);

    drive("st18", 0, 1, 4'h4, 0, 64'h18, 64'h8877665544332211, 4'hF, 4'hF, 0, 0);
    exp_w(3'd1, 4'h4, 1'b0, 64'h18, 64'd0, 4'hF, 4'hF);

    drive("st20", 0, 1, 4'h4, 0, 64'h20, 64'h0102030405060708, 4'hF, 4'hF, 0, 0);
    exp_m(64'd0, 3'd1);

    drive("st1016", 0, 1, 4'h4, 0, 64'd1016, 64'hDEADBEEFCAFEF00D, 4'hF, 4'hF, 0, 0);

    drive("ld10", 0, 1, 4'h5, 0, 64'h10, 64'd0, 4'hF, 4'h3, 0, 0);
    exp_m(64'h1122334455667788, 3'd1);
    exp_w(3'd1, 4'h5, 1'b0, 64'h10, 64'h1122334455667788, 4'hF, 4'h3);

    drive("ld1016", 0, 1, 4'h5, 0, 64'd1016, 64'd0, 4'hF, 4'h2, 0, 0);
    exp_m(64'hDEADBEEFCAFEF00D, 3'd1);

    drive("unal13", 0, 1, 4'h5, 0, 64'h13, 64'd0, 4'hF, 4'h1, 0, 0);
`ifdef DMEM_ALIGN_CHECK_EN
    exp_m(64'd0, 3'd3);
    drive("clr_adr", 1, 1, 4'h1, 0, 64'd0, 64'd0, 4'hF, 4'hF, 0, 0);
    exp_bubble();
`else
    exp_m(64'h3322111122334455, 3'd1);
    exp_w(3'd1, 4'h5, 1'b0, 64'h13, 64'h3322111122334455, 4'hF, 4'h1);
`endif

    drive("ld1017", 0, 1, 4'h5, 0, 64'd1017, 64'd0, 4'hF, 4'h4, 0, 0);
    exp_m(64'd0, 3'd3);
    exp_w(3'd3, 4'h5, 1'b0, 64'd1017, 64'd0, 4'hF, 4'h4);

    drive("push_sup", 0, 1, 4'hA, 0, 64'h20, 64'hAA, 4'h4, 4'hF, 1, 0);
    exp_m(64'd0, 3'd1);
    exp_w(3'd3, 4'h5, 1'b0, 64'd1017, 64'd0, 4'hF, 4'h4);

    drive("ld_wrap", 0, 1, 4'h5, 0, 64'hFFFFFFFFFFFFFFFC, 64'd0, 4'hF, 4'h4, 1, 0);
    exp_m(64'd0, 3'd3);
    exp_w(3'd3, 4'h5, 1'b0, 64'd1017, 64'd0, 4'hF, 4'h4);

    drive("reset2", 1, 1, 4'h1, 0, 64'd0, 64'd0, 4'hF, 4'hF, 0, 0);
    exp_bubble();

    drive("ld20", 0, 1, 4'h5, 0, 64'h20, 64'd0, 4'hF, 4'h5, 0, 0);
    exp_m(64'h0102030405060708, 3'd1);
    exp_w(3'd1, 4'h5, 1'b0, 64'h20, 64'h0102030405060708, 4'hF, 4'h5);

    drive("opq", 0, 1, 4'h6, 1, 64'd5, 64'd0, 4'h2, 4'hF, 0, 0);
    exp_m(64'd0, 3'd1);
    exp_w(3'd1, 4'h6, 1'b1, 64'd5, 64'd0, 4'h2, 4'hF);

    drive("stall", 0, 1, 4'h6, 0, 64'd9, 64'd0, 4'h7, 4'hF, 1, 0);
    exp_w(3'd1, 4'h6, 1'b1, 64'd5, 64'd0, 4'h2, 4'hF);

    drive("stall_bub", 0, 1, 4'h6, 0, 64'd9, 64'd0, 4'h7, 4'hF, 1, 1);
    exp_bubble();

    drive("st40", 0, 1, 4'h4, 0, 64'h40, 64'h99, 4'hF, 4'hF, 0, 0);
    exp_w(3'd1, 4'h4, 1'b0, 64'h40, 64'd0, 4'hF, 4'hF);

    drive("popq", 0, 1, 4'hB, 0, 64'h48, 64'h40, 4'h4, 4'h6, 0, 0);
    exp_m(64'h99, 3'd1);
    exp_w(3'd1, 4'hB, 1'b0, 64'h48, 64'h99, 4'h4, 4'h6);

    drive("st_rst", 1, 1, 4'h4, 0, 64'h40, 64'h77, 4'hF, 4'hF, 0, 0);
    exp_m(64'd0, 3'd1);
    exp_bubble();

    drive("ret", 0, 1, 4'h9, 0, 64'h50, 64'h40, 4'h4, 4'hF, 0, 0);
    exp_m(64'h99, 3'd1);
    exp_w(3'd1, 4'h9, 1'b0, 64'h50, 64'h99, 4'h4, 4'hF);

    drive("call", 0, 1, 4'h8, 0, 64'h60, 64'h1234, 4'h4, 4'hF, 0, 0);
    exp_m(64'd0, 3'd1);

    drive("st_hlt", 0, 2, 4'h4, 0, 64'h60, 64'h5555, 4'hF, 4'hF, 0, 0);
    exp_w(3'd2, 4'h4, 1'b0, 64'h60, 64'd0, 4'hF, 4'hF);

    drive("ret60", 0, 1, 4'h9, 0, 64'h68, 64'h60, 4'h4, 4'hF, 0, 0);
    exp_m(64'h1234, 3'd1);
    exp_w(3'd1, 4'h9, 1'b0, 64'h68, 64'h1234, 4'h4, 4'hF);

    drive("idle", 0, 1, 4'h1, 0, 64'd0, 64'd0, 4'hF, 4'hF, 0, 0);
    exp_w(3'd1, 4'h1, 1'b0, 64'd0, 64'd0, 4'hF, 4'hF);
    drive("drain", 0, 1, 4'h1, 0, 64'd0, 64'd0, 4'hF, 4'hF, 0, 0);
    @(posedge clk);
    @(negedge clk);
    #1;

    if (mq.size() != 0 || wq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d unchecked entries, want 0", mq.size() + wq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
